// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive frame timer: phase encodings and
// the minimum oversampling prescale the bit-centre sampler can work with.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    PH_IDLE   = 3'd0,
    PH_START  = 3'd1,
    PH_DATA   = 3'd2,
    PH_PARITY = 3'd3,
    PH_STOP   = 3'd4
  } phase_e;

  // Three samples around p/2 plus a decision edge must fit before the bit wraps.
  localparam int MIN_PRESCALE = 6;

endpackage

// File: rtl/uart_rx_sample_vote.sv
// Bit-centre sampler: captures rx_in at edges p/2-1 and p/2 and decides at p/2+1.
// UART_RX_MAJORITY_VOTE_EN selects a 2-of-3 vote; otherwise the p/2 sample wins.
module uart_rx_sample_vote #(
  parameter int CNT_W = 6
) (
  input  logic             rx_clk,
  input  logic             rst_n,
  input  logic             active,
  input  logic [CNT_W-1:0] cnt,
  input  logic [CNT_W-1:0] half,
  input  logic             rx_in,
  output logic             decide,
  output logic             bit_dec
);

  // sr[1] holds the p/2-1 sample, sr[0] the p/2 sample; the third is rx_in live.
  logic [1:0] sr;
  logic       sample_en;

  assign sample_en = active && ((cnt == half - 1'b1) || (cnt == half));

  always_ff @(posedge rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      sr <= '0;
    end else if (sample_en) begin
      // NOTE: non-blocking so every flop updates from pre-edge values, avoiding order races.
      sr <= {sr[0], rx_in};
    end
  end

  always_comb begin
    decide = active && (cnt == half + 1'b1);
`ifdef UART_RX_MAJORITY_VOTE_EN
    bit_dec = (sr[1] & sr[0]) | (sr[1] & rx_in) | (sr[0] & rx_in);
`else
    bit_dec = sr[0];
`endif
  end

`ifndef UART_RX_MAJORITY_VOTE_EN
  logic unused_early_sample;
  assign unused_early_sample = sr[1];
`endif

endmodule

// File: rtl/uart_rx_frame_timer.sv
// UART receive frame timer: tracks start/data/parity/stop bit timing on an
// oversampled line and reports each decided bit. Option: UART_RX_MAJORITY_VOTE_EN.
module uart_rx_frame_timer
  import uart_rx_pkg::*;
#(
  parameter int PRESCALE_W    = 6,
  parameter int MAX_DATA_BITS = 9
) (
  input  logic                  rx_clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  rx_in,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic [3:0]            cfg_data_bits,
  input  logic                  cfg_par_en,
  input  logic                  cfg_stop2,
  output logic                  bit_valid,
  output logic                  bit_value,
  output logic [3:0]            bit_index,
  output logic [2:0]            phase,
  output logic                  frame_done,
  output logic                  stop_err,
  output logic                  start_glitch
);

  localparam logic [PRESCALE_W-1:0] MIN_P  = PRESCALE_W'(MIN_PRESCALE);
  localparam logic [3:0]            MAX_NB = 4'(MAX_DATA_BITS);
  localparam logic [3:0]            MIN_NB = 4'd5;

  phase_e                state;
  logic [PRESCALE_W-1:0] cnt;
  logic [PRESCALE_W-1:0] p_lat;
  logic [PRESCALE_W-1:0] half;
  logic [PRESCALE_W-1:0] p_eff;
  logic [3:0]            nb_lat;
  logic [3:0]            nb_eff;
  logic [3:0]            data_idx;
  logic                  par_lat;
  logic                  stop2_lat;
  logic                  stop_idx;
  logic                  last_edge;
  logic                  decide;
  logic                  bit_dec;

  // Out-of-range settings are clamped once, at frame start, so a frame never
  // runs with a timing the sampler cannot support.
  assign p_eff  = (prescale < MIN_P) ? MIN_P : prescale;
  assign nb_eff = (cfg_data_bits < MIN_NB || cfg_data_bits > MAX_NB) ? MAX_NB : cfg_data_bits;

  assign half      = p_lat >> 1;
  assign last_edge = (cnt == p_lat - 1'b1);
  assign phase     = state;
  assign bit_index = data_idx;

  uart_rx_sample_vote #(
    .CNT_W(PRESCALE_W)
  ) u_vote (
    .rx_clk (rx_clk),
    .rst_n  (rst_n),
    .active (enable && (state != PH_IDLE)),
    .cnt    (cnt),
    .half   (half),
    .rx_in  (rx_in),
    .decide (decide),
    .bit_dec(bit_dec)
  );

  always_ff @(posedge rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= PH_IDLE;
      cnt          <= '0;
      p_lat        <= '0;
      nb_lat       <= '0;
      par_lat      <= 1'b0;
      stop2_lat    <= 1'b0;
      data_idx     <= '0;
      stop_idx     <= 1'b0;
      bit_valid    <= 1'b0;
      bit_value    <= 1'b0;
      frame_done   <= 1'b0;
      stop_err     <= 1'b0;
      start_glitch <= 1'b0;
    end else begin
      bit_valid    <= 1'b0;
      frame_done   <= 1'b0;
      stop_err     <= 1'b0;
      start_glitch <= 1'b0;

      if (!enable) begin
        state     <= PH_IDLE;
        cnt       <= '0;
        data_idx  <= '0;
        stop_idx  <= 1'b0;
        bit_value <= 1'b0;
      end else if (state == PH_IDLE) begin
        if (!rx_in) begin
          state     <= PH_START;
          cnt       <= '0;
          p_lat     <= p_eff;
          nb_lat    <= nb_eff;
          par_lat   <= cfg_par_en;
          stop2_lat <= cfg_stop2;
          data_idx  <= '0;
          stop_idx  <= 1'b0;
        end
      end else begin
        cnt <= last_edge ? '0 : cnt + 1'b1;

        if (decide) begin
          if (state == PH_START && bit_dec) begin
            // A high start sample means the falling edge was noise: abandon quietly.
            start_glitch <= 1'b1;
            state        <= PH_IDLE;
            cnt          <= '0;
          end else begin
            bit_valid <= 1'b1;
            bit_value <= bit_dec;
            stop_err  <= (state == PH_STOP) && !bit_dec;
          end
        end

        if (last_edge) begin
          case (state)
            PH_START: begin
              state    <= PH_DATA;
              data_idx <= '0;
            end
            PH_DATA: begin
              if (data_idx == nb_lat - 4'd1) begin
                data_idx <= '0;
                stop_idx <= 1'b0;
                state    <= par_lat ? PH_PARITY : PH_STOP;
              end else begin
                data_idx <= data_idx + 4'd1;
              end
            end
            PH_PARITY: begin
              stop_idx <= 1'b0;
              state    <= PH_STOP;
            end
            PH_STOP: begin
              if (!stop2_lat || stop_idx) begin
                frame_done <= 1'b1;
                stop_idx   <= 1'b0;
                state      <= PH_IDLE;
              end else begin
                stop_idx <= 1'b1;
              end
            end
            default: state <= PH_IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_frame_timer.sv
// Scoreboard bench for uart_rx_frame_timer: directed frames push expected bit,
// frame_done and start_glitch events; a negedge monitor pops and compares them.
module tb_uart_rx_frame_timer;

  localparam int PW = 6;

  logic          rx_clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic          rx_in;
  logic [PW-1:0] prescale;
  logic [3:0]    cfg_data_bits;
  logic          cfg_par_en;
  logic          cfg_stop2;
  logic          bit_valid;
  logic          bit_value;
  logic [3:0]    bit_index;
  logic [2:0]    phase;
  logic          frame_done;
  logic          stop_err;
  logic          start_glitch;

  typedef struct {
    logic       v;
    logic [3:0] idx;
    logic [2:0] ph;
    logic       err;
  } bit_ev_t;

  bit_ev_t exp_bits[$];
  int      exp_done[$];
  int      exp_glitch[$];
  int      cyc = 0;
  int      checks = 0;
  int      errors = 0;

  uart_rx_frame_timer #(.PRESCALE_W(PW), .MAX_DATA_BITS(9)) dut (
    .rx_clk       (rx_clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .rx_in        (rx_in),
    .prescale     (prescale),
    .cfg_data_bits(cfg_data_bits),
    .cfg_par_en   (cfg_par_en),
    .cfg_stop2    (cfg_stop2),
    .bit_valid    (bit_valid),
    .bit_value    (bit_value),
    .bit_index    (bit_index),
    .phase        (phase),
    .frame_done   (frame_done),
    .stop_err     (stop_err),
    .start_glitch (start_glitch)
  );

  always #5 rx_clk = ~rx_clk;
  always @(posedge rx_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [11:0] all_outputs();
    return {bit_valid, bit_value, bit_index, phase, frame_done, stop_err, start_glitch};
  endfunction

  // Monitor: every DUT pulse must match the head of its expectation queue.
  initial begin
    bit_ev_t e;
    int      t;
    forever begin
      @(negedge rx_clk);
      if (bit_valid) begin
        if (exp_bits.size() == 0) check("unexpected_bit_valid", 1, 0);
        else begin
          e = exp_bits.pop_front();
          check("bit_event {value,index,phase,stop_err}",
                {bit_value, bit_index, phase, stop_err}, {e.v, e.idx, e.ph, e.err});
        end
      end else if (stop_err) begin
        check("stop_err_without_bit_valid", 1, 0);
      end
      if (frame_done) begin
        if (exp_done.size() == 0) check("unexpected_frame_done", 1, 0);
        else begin
          t = exp_done.pop_front();
          check("frame_done_cycle", cyc, t);
        end
      end
      if (start_glitch) begin
        if (exp_glitch.size() == 0) check("unexpected_start_glitch", 1, 0);
        else begin
          t = exp_glitch.pop_front();
          check("start_glitch_cycle", cyc, t);
          check("start_glitch_phase_idle", {bit_valid, phase}, 4'd0);
        end
      end
    end
  end

  // Drives one frame starting at the current negedge. glitch_k/abort_k index the
  // bit list (0 = start bit); -1 disables them. p/nb are the effective values.
  task automatic send_frame(input logic [PW-1:0] cfg_p, input logic [3:0] cfg_nb,
                            input int p, input int nb, input logic par_en, input logic stop2,
                            input logic [8:0] data, input logic stop_val,
                            input int glitch_k, input int abort_k);
    logic       bits[16];
    logic [2:0] phs[16];
    logic [3:0] idxs[16];
    logic       par;
    int         n;
    int         t0;
    bit_ev_t    e;
    n = 0;
    bits[n] = 1'b0; phs[n] = 3'd1; idxs[n] = 4'd0; n++;
    par = 1'b0;
    for (int i = 0; i < nb; i++) begin
      bits[n] = data[i]; phs[n] = 3'd2; idxs[n] = 4'(i); n++;
      par ^= data[i];
    end
    if (par_en) begin bits[n] = par; phs[n] = 3'd3; idxs[n] = 4'd0; n++; end
    for (int s = 0; s < (stop2 ? 2 : 1); s++) begin
      bits[n] = stop_val; phs[n] = 3'd4; idxs[n] = 4'd0; n++;
    end

    prescale = cfg_p; cfg_data_bits = cfg_nb; cfg_par_en = par_en; cfg_stop2 = stop2;
    rx_in = 1'b0;
    t0 = cyc;
    for (int k = 0; k < n; k++) begin
      if (k == abort_k) begin
        repeat (2) @(negedge rx_clk);
        enable = 1'b0;
        return;
      end
      e.v = bits[k];
`ifndef UART_RX_MAJORITY_VOTE_EN
      if (k == glitch_k) e.v = ~bits[k];
`endif
      e.idx = idxs[k]; e.ph = phs[k]; e.err = (phs[k] == 3'd4) && !bits[k];
      exp_bits.push_back(e);
      rx_in = bits[k];
      if (k == glitch_k) begin
        repeat (p / 2 + 1) @(negedge rx_clk);
        rx_in = ~bits[k];
        @(negedge rx_clk);
        rx_in = bits[k];
        repeat (p - p / 2 - 2) @(negedge rx_clk);
      end else begin
        repeat (p) @(negedge rx_clk);
      end
      if (k == 0) begin
        // Mid-frame config changes must not disturb the running frame.
        prescale = 6'd7; cfg_data_bits = 4'd5; cfg_par_en = ~par_en; cfg_stop2 = ~stop2;
      end
    end
    exp_done.push_back(t0 + 1 + n * p);
    rx_in = 1'b1;
    @(negedge rx_clk);
  endtask

  task automatic send_glitch(input int p, input int len);
    prescale = PW'(p); cfg_data_bits = 4'd8; cfg_par_en = 1'b0; cfg_stop2 = 1'b0;
    rx_in = 1'b0;
    exp_glitch.push_back(cyc + 1 + p / 2 + 2);
    repeat (len) @(negedge rx_clk);
    rx_in = 1'b1;
    repeat (2 * p) @(negedge rx_clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; enable = 1'b0; rx_in = 1'b1;
    prescale = 6'd8; cfg_data_bits = 4'd8; cfg_par_en = 1'b0; cfg_stop2 = 1'b0;
    repeat (3) @(negedge rx_clk);
    check("reset_outputs", all_outputs(), 12'd0);
    rst_n = 1'b1; enable = 1'b1;
    repeat (2) @(negedge rx_clk);
    check("idle_after_reset", all_outputs(), 12'd0);

    // 8N1 0xA5 at prescale 8: 80-cycle frame
    send_frame(6'd8, 4'd8, 8, 8, 1'b0, 1'b0, 9'h0A5, 1'b1, -1, -1);
    repeat (4) @(negedge rx_clk);
    // 7E2 at prescale 16: 176-cycle frame
    send_frame(6'd16, 4'd7, 16, 7, 1'b1, 1'b1, 9'h031, 1'b1, -1, -1);
    repeat (4) @(negedge rx_clk);
    // 3-cycle low pulse on the idle line
    send_glitch(8, 3);
    // Stop bit forced low, then a back-to-back frame in the IDLE cycle after frame_done
    send_frame(6'd8, 4'd8, 8, 8, 1'b0, 1'b0, 9'h03C, 1'b0, -1, -1);
    send_frame(6'd8, 4'd8, 8, 8, 1'b0, 1'b0, 9'h05A, 1'b1, -1, -1);
    repeat (4) @(negedge rx_clk);
    // One-cycle glitch at edge p/2 of data bit 3 (bit-list index 4)
    send_frame(6'd8, 4'd8, 8, 8, 1'b0, 1'b0, 9'h0A5, 1'b1, 4, -1);
    repeat (4) @(negedge rx_clk);
    // Illegal settings clamp: prescale 3 -> 6, data bits 0 -> 9
    send_frame(6'd3, 4'd0, 6, 9, 1'b0, 1'b0, 9'h1C3, 1'b1, -1, -1);
    repeat (4) @(negedge rx_clk);

    // Enable dropped two cycles into data bit 2, then a reset pulse
    send_frame(6'd8, 4'd8, 8, 8, 1'b0, 1'b0, 9'h0FF, 1'b1, -1, 3);
    rx_in = 1'b1;
    @(negedge rx_clk);
    check("disable_idle_outputs", all_outputs(), 12'd0);
    rst_n = 1'b0;
    #1;
    check("midframe_reset_outputs", all_outputs(), 12'd0);
    @(negedge rx_clk);
    rst_n = 1'b1; enable = 1'b1;
    @(negedge rx_clk);
    send_frame(6'd8, 4'd8, 8, 8, 1'b0, 1'b0, 9'h096, 1'b1, -1, -1);

    repeat (40) @(negedge rx_clk);
    check("pending_bit_events", exp_bits.size(), 0);
    check("pending_frame_done", exp_done.size(), 0);
    check("pending_start_glitch", exp_glitch.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
